// File: rtl/mastermind_core.sv
// Mastermind scoring core: holds a secret pattern, grades guesses into
// red (exact position) and white (colour-only) counts, tracks rounds and
// reports win/loss.
// Optional feature macro: MASTERMIND_ROUND_LIMIT_EN enables the lose-on-last-round
// rule; without it the round counter saturates and play continues until a win.
module mastermind_core #(
    parameter int unsigned NUM_PEGS   = 4,
    parameter int unsigned COLOR_W    = 3,
    parameter int unsigned MAX_ROUNDS = 10,
    localparam int unsigned CW        = $clog2(NUM_PEGS + 1),
    localparam int unsigned RW        = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_game,
    input  logic                        pattern_load,
    input  logic [NUM_PEGS*COLOR_W-1:0] pattern_in,
    input  logic                        grade_it,
    input  logic [NUM_PEGS*COLOR_W-1:0] guess,
    output logic [CW-1:0]               red,
    output logic [CW-1:0]               white,
    output logic                        fb_valid,
    output logic                        busy,
    output logic [RW-1:0]               round_number,
    output logic                        won,
    output logic                        lost
);

    localparam int unsigned NCOLORS = 1 << COLOR_W;
    localparam int unsigned PW      = NUM_PEGS * COLOR_W;

    typedef enum logic [2:0] {
        StIdle,
        StWaitGuess,
        StGrade,
        StWon,
        StLost
    } state_e;

    state_e             state_q;
    logic [PW-1:0]      pattern_q;
    logic [PW-1:0]      guess_q;
    // One extra bit so the counter can reach NCOLORS, marking the finish cycle.
    logic [COLOR_W:0]   color_q;
    logic [CW-1:0]      match_q;
    logic [CW-1:0]      red_q;
    logic [CW-1:0]      white_q;
    logic               fb_valid_q;
    logic [RW-1:0]      round_q;
    logic               won_q;
    logic               lost_q;

    logic [CW-1:0]      exact_cnt;
    logic [CW-1:0]      guess_cnt;
    logic [CW-1:0]      pattern_cnt;
    logic [CW-1:0]      color_min;
    logic [COLOR_W-1:0] cur_color;

    // Exact-position matches between the incoming guess and the stored pattern.
    always_comb begin
        exact_cnt = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (guess[i*COLOR_W +: COLOR_W] == pattern_q[i*COLOR_W +: COLOR_W]) begin
                exact_cnt = exact_cnt + CW'(1);
            end
        end
    end

    // Occurrences of the current colour in guess and pattern; the smaller counts as matched.
    always_comb begin
        cur_color   = color_q[COLOR_W-1:0];
        guess_cnt   = '0;
        pattern_cnt = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (guess_q[i*COLOR_W +: COLOR_W] == cur_color) begin
                guess_cnt = guess_cnt + CW'(1);
            end
            if (pattern_q[i*COLOR_W +: COLOR_W] == cur_color) begin
                pattern_cnt = pattern_cnt + CW'(1);
            end
        end
        color_min = (guess_cnt < pattern_cnt) ? guess_cnt : pattern_cnt;
    end

    // Game FSM with all outputs registered; start_game overrides every state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            pattern_q  <= '0;
            guess_q    <= '0;
            color_q    <= '0;
            match_q    <= '0;
            red_q      <= '0;
            white_q    <= '0;
            fb_valid_q <= 1'b0;
            round_q    <= '0;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            fb_valid_q <= 1'b0;
            if (start_game) begin
                if (state_q == StIdle && pattern_load) begin
                    pattern_q <= pattern_in;
                end
                state_q <= StWaitGuess;
                round_q <= RW'(1);
                won_q   <= 1'b0;
                lost_q  <= 1'b0;
                red_q   <= '0;
                white_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (pattern_load) begin
                            pattern_q <= pattern_in;
                        end
                    end
                    StWaitGuess: begin
                        if (grade_it) begin
                            guess_q <= guess;
                            red_q   <= exact_cnt;
                            color_q <= '0;
                            match_q <= '0;
                            state_q <= StGrade;
                        end
                    end
                    StGrade: begin
                        if (color_q == (COLOR_W + 1)'(NCOLORS)) begin
                            // All colours accumulated: publish feedback and decide outcome.
                            white_q    <= match_q - red_q;
                            fb_valid_q <= 1'b1;
                            if (red_q == CW'(NUM_PEGS)) begin
                                won_q   <= 1'b1;
                                state_q <= StWon;
`ifdef MASTERMIND_ROUND_LIMIT_EN
                            end else if (round_q == RW'(MAX_ROUNDS)) begin
                                lost_q  <= 1'b1;
                                state_q <= StLost;
                            end else begin
                                round_q <= round_q + RW'(1);
                                state_q <= StWaitGuess;
                            end
`else
                            end else begin
                                if (round_q != RW'(MAX_ROUNDS)) begin
                                    round_q <= round_q + RW'(1);
                                end
                                state_q <= StWaitGuess;
                            end
`endif
                        end else begin
                            match_q <= match_q + color_min;
                            color_q <= color_q + (COLOR_W + 1)'(1);
                        end
                    end
                    StWon, StLost: begin
                        // Frozen until start_game or reset.
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign red          = red_q;
    assign white        = white_q;
    assign fb_valid     = fb_valid_q;
    assign busy         = (state_q == StGrade);
    assign round_number = round_q;
    assign won          = won_q;
    assign lost         = lost_q;

endmodule

// File: tb/tb_mastermind_core.sv
// Directed self-checking bench for mastermind_core (default parameters).
module tb_mastermind_core;

    localparam int NUM_PEGS   = 4;
    localparam int COLOR_W    = 3;
    localparam int MAX_ROUNDS = 10;
    localparam int W          = NUM_PEGS * COLOR_W;
    localparam int LAT        = (1 << COLOR_W) + 1;

    logic         clock;
    logic         reset;
    logic         start_game;
    logic         pattern_load;
    logic [W-1:0] pattern_in;
    logic         grade_it;
    logic [W-1:0] guess;
    logic [2:0]   red;
    logic [2:0]   white;
    logic         fb_valid;
    logic         busy;
    logic [3:0]   round_number;
    logic         won;
    logic         lost;

    int total = 0;
    int bad   = 0;

    mastermind_core #(
        .NUM_PEGS  (NUM_PEGS),
        .COLOR_W   (COLOR_W),
        .MAX_ROUNDS(MAX_ROUNDS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_game  (start_game),
        .pattern_load(pattern_load),
        .pattern_in  (pattern_in),
        .grade_it    (grade_it),
        .guess       (guess),
        .red         (red),
        .white       (white),
        .fb_valid    (fb_valid),
        .busy        (busy),
        .round_number(round_number),
        .won         (won),
        .lost        (lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Load a pattern and start a game in the same cycle.
    task automatic do_start(input logic [W-1:0] p);
        @(negedge clock);
        pattern_in   = p;
        pattern_load = 1'b1;
        start_game   = 1'b1;
        @(negedge clock);
        pattern_load = 1'b0;
        start_game   = 1'b0;
    endtask

    // Submit a guess; returns edges from acceptance to fb_valid (99 on timeout)
    // and busy as seen one edge after acceptance.
    task automatic do_grade(input logic [W-1:0] g, output int lat, output logic busy1);
        @(negedge clock);
        guess    = g;
        grade_it = 1'b1;
        @(posedge clock);
        #1;
        grade_it = 1'b0;
        lat      = 99;
        busy1    = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock);
            #1;
            if (n == 1) busy1 = busy;
            if (fb_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        total++;
        if ({red, white, fb_valid, busy, round_number, won, lost} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got red=%0d white=%0d fb=%0b busy=%0b rnd=%0d won=%0b lost=%0b want all 0",
                     red, white, fb_valid, busy, round_number, won, lost);
        end
    endtask

    task automatic test_win();
        int   lat;
        logic b1;
        int   pulses;
        do_start(12'o2425);
        total++;
        if (round_number !== 4'd1) begin
            bad++; $display("FAIL start_round: got %0d want 1", round_number);
        end
        do_grade(12'o2425, lat, b1);
        total++;
        if (lat !== LAT) begin
            bad++; $display("FAIL win_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (b1 !== 1'b1) begin
            bad++; $display("FAIL busy_in_grade: got %0b want 1", b1);
        end
        total++;
        if ({red, white, won, lost, round_number} !== {3'd4, 3'd0, 1'b1, 1'b0, 4'd1}) begin
            bad++;
            $display("FAIL win_result: got red=%0d white=%0d won=%0b lost=%0b rnd=%0d want 4 0 1 0 1",
                     red, white, won, lost, round_number);
        end
        // Grading must be ignored once the game is won.
        @(negedge clock);
        grade_it = 1'b1;
        guess    = 12'o0000;
        pulses   = 0;
        repeat (14) begin
            @(posedge clock);
            #1;
            if (fb_valid) pulses++;
        end
        grade_it = 1'b0;
        total++;
        if ({pulses[3:0], red, won, busy, round_number} !== {4'd0, 3'd4, 1'b1, 1'b0, 4'd1}) begin
            bad++;
            $display("FAIL won_frozen: got pulses=%0d red=%0d won=%0b busy=%0b rnd=%0d want 0 4 1 0 1",
                     pulses, red, won, busy, round_number);
        end
    endtask

    task automatic test_colors();
        int   lat;
        logic b1;
        do_start(12'o2425);
        do_grade(12'o5242, lat, b1);
        total++;
        if ({red, white, won, round_number} !== {3'd0, 3'd4, 1'b0, 4'd2} || lat !== LAT) begin
            bad++;
            $display("FAIL all_white: got red=%0d white=%0d won=%0b rnd=%0d lat=%0d want 0 4 0 2 %0d",
                     red, white, won, round_number, lat, LAT);
        end
        do_grade(12'o2222, lat, b1);
        total++;
        if ({red, white, won, round_number} !== {3'd2, 3'd0, 1'b0, 4'd3}) begin
            bad++;
            $display("FAIL dup_colors: got red=%0d white=%0d won=%0b rnd=%0d want 2 0 0 3",
                     red, white, won, round_number);
        end
        do_grade(12'o0000, lat, b1);
        total++;
        if ({red, white, round_number} !== {3'd0, 3'd0, 4'd4}) begin
            bad++;
            $display("FAIL no_match: got red=%0d white=%0d rnd=%0d want 0 0 4", red, white, round_number);
        end
        // Same colour set, one exact: pattern pegs 5,2,4,2 vs guess 2,2,5,4.
        do_grade(12'o4522, lat, b1);
        total++;
        if ({red, white, round_number} !== {3'd1, 3'd3, 4'd5}) begin
            bad++;
            $display("FAIL mixed: got red=%0d white=%0d rnd=%0d want 1 3 5", red, white, round_number);
        end
    endtask

    task automatic test_round_limit();
        int   lat;
        logic b1;
        do_start(12'o2425);
        for (int k = 1; k <= MAX_ROUNDS; k++) begin
            do_grade(12'o0000, lat, b1);
            if (k == 9) begin
                total++;
                if (round_number !== 4'd10 || lost !== 1'b0) begin
                    bad++;
                    $display("FAIL round9: got rnd=%0d lost=%0b want 10 0", round_number, lost);
                end
            end
        end
`ifdef MASTERMIND_ROUND_LIMIT_EN
        total++;
        if ({lost, won, round_number} !== {1'b1, 1'b0, 4'd10}) begin
            bad++;
            $display("FAIL lost_after_10: got lost=%0b won=%0b rnd=%0d want 1 0 10", lost, won, round_number);
        end
`else
        total++;
        if ({lost, won, round_number} !== {1'b0, 1'b0, 4'd10}) begin
            bad++;
            $display("FAIL no_limit_10: got lost=%0b won=%0b rnd=%0d want 0 0 10", lost, won, round_number);
        end
        do_grade(12'o2425, lat, b1);
        total++;
        if ({won, lost, red, round_number} !== {1'b1, 1'b0, 3'd4, 4'd10} || lat !== LAT) begin
            bad++;
            $display("FAIL win_round11: got won=%0b lost=%0b red=%0d rnd=%0d lat=%0d want 1 0 4 10 %0d",
                     won, lost, red, round_number, lat, LAT);
        end
`endif
    endtask

    task automatic test_hold_grade();
        int pulses;
        int first_at;
        do_start(12'o2425);
        @(negedge clock);
        guess    = 12'o0000;
        grade_it = 1'b1;
        @(posedge clock);
        pulses   = 0;
        first_at = 0;
        for (int n = 1; n <= LAT; n++) begin
            @(posedge clock);
            #1;
            if (fb_valid) begin
                pulses++;
                if (first_at == 0) first_at = n;
            end
        end
        grade_it = 1'b0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (fb_valid) pulses++;
        end
        total++;
        if (pulses !== 1 || first_at !== LAT || round_number !== 4'd2) begin
            bad++;
            $display("FAIL hold_grade: got pulses=%0d at=%0d rnd=%0d want 1 %0d 2",
                     pulses, first_at, round_number, LAT);
        end
    endtask

    task automatic test_reset_mid_grade();
        int pulses;
        do_start(12'o2425);
        @(negedge clock);
        guess    = 12'o2425;
        grade_it = 1'b1;
        @(posedge clock);
        #1;
        grade_it = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if ({red, white, fb_valid, busy, round_number, won, lost} !== 13'd0) begin
            bad++;
            $display("FAIL reset_mid_grade: got red=%0d white=%0d fb=%0b busy=%0b rnd=%0d won=%0b lost=%0b want all 0",
                     red, white, fb_valid, busy, round_number, won, lost);
        end
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clock);
            #1;
            if (fb_valid) pulses++;
        end
        total++;
        if (pulses !== 0 || won !== 1'b0 || round_number !== 4'd0) begin
            bad++;
            $display("FAIL after_abort: got pulses=%0d won=%0b rnd=%0d want 0 0 0", pulses, won, round_number);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start_game   = 1'b0;
        pattern_load = 1'b0;
        pattern_in   = '0;
        grade_it     = 1'b0;
        guess        = '0;
        test_reset();
        test_win();
        test_colors();
        test_round_limit();
        test_hold_grade();
        test_reset_mid_grade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mastermind_core.md
MASTERMIND_CORE -- requirements
Module: mastermind_core

Interface
REQ-001 SHALL have parameter NUM_PEGS, default 4: pegs per pattern/guess, range 2..8.
REQ-002 SHALL have parameter COLOR_W, default 3: bits per peg; NCOLORS = 2^COLOR_W.
REQ-003 SHALL have parameter MAX_ROUNDS, default 10: guesses allowed per game, range 1..15.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clock  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port start_game  in  1  begins a new game.
REQ-008 SHALL have port pattern_load  in  1  captures pattern_in.
REQ-009 SHALL have port pattern_in  in  NUM_PEGS*COLOR_W  secret code; peg i = bits [i*COLOR_W +: COLOR_W].
REQ-010 SHALL have port grade_it  in  1  submits guess.
REQ-011 SHALL have port guess  in  NUM_PEGS*COLOR_W  guess, same peg packing.
REQ-012 SHALL have port red, white  out  CW = clog2(NUM_PEGS+1) each  exact-match and colour-only-match counts.
REQ-013 SHALL have port fb_valid  out  1  one-cycle pulse when red/white are updated.
REQ-014 SHALL have port busy  out  1  high while state is GRADE.
REQ-015 SHALL have port round_number  out  RW = clog2(MAX_ROUNDS+1)  current round.
REQ-016 SHALL have ports won, lost  out  1 each  game-over flags.

Function
REQ-017 SHALL implement states IDLE, WAIT_GUESS, GRADE, WON, LOST.
REQ-018 SHALL, in IDLE, capture pattern_in into an internal register on pattern_load; pattern_load is ignored in all other states.
REQ-019 SHALL, on start_game in any non-reset cycle, go to WAIT_GUESS, set round_number = 1, clear won/lost/red/white; start_game has priority over grade_it; with pattern_load high in the same IDLE cycle the new pattern is used.
REQ-020 SHALL, in WAIT_GUESS on grade_it, register guess, latch red = count of pegs with guess[i]==pattern[i], and enter GRADE.
REQ-021 SHALL, in GRADE, step colour index c = 0..NCOLORS-1, one colour per cycle, accumulating min(guess count of c, pattern count of c) into an internal match total.
REQ-022 SHALL, after the final colour, set white = match total - red and pulse fb_valid; fb_valid rises exactly NCOLORS+1 edges after the accepting edge.
REQ-023 SHALL ignore grade_it while in GRADE, WON or LOST; busy = 1 only in GRADE.
REQ-024 SHALL, on completing GRADE, go to WON with won = 1 if red == NUM_PEGS (win takes priority on the last round).
REQ-025 SHALL, if not won and round_number == MAX_ROUNDS, go to LOST with lost = 1 (see REQ-031).
REQ-026 SHALL otherwise increment round_number and return to WAIT_GUESS.
REQ-027 SHALL hold WON/LOST, with red/white/round_number frozen, until start_game or reset.
REQ-028 SHALL keep red + white <= NUM_PEGS for all inputs, including duplicate colours.

Reset
REQ-029 SHALL, on reset, enter IDLE; red = 0, white = 0, fb_valid = 0, busy = 0, round_number = 0, won = 0, lost = 0, pattern register = 0.
REQ-030 SHALL let reset during GRADE abort grading with no fb_valid pulse; reset has priority over all inputs.

Configuration
REQ-031 SHALL honour macro MASTERMIND_ROUND_LIMIT_EN: when defined, REQ-025 applies. When undefined, LOST is never entered, lost stays 0, and round_number saturates at MAX_ROUNDS while play continues until a win.

Verification
REQ-032 SHALL cover: defaults, pattern o2425 loaded and started, guess o2425 -> fb_valid 9 edges later, red 4, white 0, won 1, round_number 1.
REQ-033 SHALL cover: pattern o2425, guess o5242 -> red 0, white 4, won 0, round_number becomes 2.
REQ-034 SHALL cover: pattern o2425, guess o2222 -> red 2, white 0; then guess o0000 -> red 0, white 0.
REQ-035 SHALL cover: ten wrong guesses o0000 -> lost 1 after the 10th fb_valid, round_number 10; with macro undefined -> lost 0, round_number stays 10, an 11th guess o2425 gives won 1.
REQ-036 SHALL cover: grade_it held high through GRADE -> exactly one fb_valid per accepted guess; reset asserted mid-GRADE -> IDLE, no fb_valid, all outputs 0.
